// File: rtl/iir_coeff_ctrl_pkg.sv
// Shared types and constants for the IIR coefficient controller: address map,
// FSM states and the packed layout of one coefficient bank.
package iir_ctrl_pkg;

    localparam int unsigned CX_W      = 40;
    localparam int unsigned CY_W      = 24;
    localparam int unsigned XS_W      = 8;
    localparam int unsigned BYTE_W    = 8;
    localparam int unsigned ADDR_W    = 5;

    localparam logic [ADDR_W-1:0] ADDR_CX   = 5'd0;
    localparam logic [ADDR_W-1:0] ADDR_CX0  = 5'd5;
    localparam logic [ADDR_W-1:0] ADDR_CX1  = 5'd6;
    localparam logic [ADDR_W-1:0] ADDR_CX2  = 5'd7;
    localparam logic [ADDR_W-1:0] ADDR_CY0  = 5'd8;
    localparam logic [ADDR_W-1:0] ADDR_CY1  = 5'd11;
    localparam logic [ADDR_W-1:0] ADDR_CY2  = 5'd14;
    localparam logic [ADDR_W-1:0] ADDR_LAST = 5'd16;

    localparam int unsigned NUM_BYTES = 32'(ADDR_LAST) + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PEND  = 2'd1,
        FLUSH = 2'd2
    } state_t;

    // Field order puts cx in the low bits so a flat little-endian byte array
    // (byte 0 at bits 7:0) casts directly onto the bank.
    typedef struct packed {
        logic [CY_W-1:0] cy2;
        logic [CY_W-1:0] cy1;
        logic [CY_W-1:0] cy0;
        logic [XS_W-1:0] cx2;
        logic [XS_W-1:0] cx1;
        logic [XS_W-1:0] cx0;
        logic [CX_W-1:0] cx;
    } coeff_t;

    function automatic logic addr_valid(input logic [ADDR_W-1:0] addr);
        return addr <= ADDR_LAST;
    endfunction

endpackage

// File: rtl/iir_coeff_ctrl_if.sv
// HPS configuration bus into the coefficient controller: byte writes, commit
// request and the busy / error status returned to the host.
interface iir_coeff_ctrl_if;
    import iir_ctrl_pkg::*;

    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [BYTE_W-1:0] wr_data;
    logic              commit;
    logic              busy;
    logic              wr_err;

    modport master (
        output wr_en, wr_addr, wr_data, commit,
        input  busy, wr_err
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, commit,
        output busy, wr_err
    );

endinterface

// File: rtl/iir_ce_gen.sv
// Free-running strobe generator: ce once every DIV clocks, sample_ce on every
// second ce (stereo) or every ce (mono).
module iir_ce_gen #(
    parameter int unsigned DIV    = 512,
    parameter bit          STEREO = 1'b1
) (
    input  logic clk,
    input  logic reset,
    output logic ce,
    output logic sample_ce
);

    localparam int unsigned CNT_W = (DIV > 1) ? $clog2(DIV) : 1;

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ce_q, ce_d;
    logic             sample_ce_q, sample_ce_d;
    logic             phase_q, phase_d;

    // ce is decoded one count early so the registered pulse lines up with cnt==DIV-1.
    always_comb begin
        cnt_d       = cnt_q + CNT_W'(1);
        ce_d        = 1'b0;
        sample_ce_d = 1'b0;
        phase_d     = phase_q ^ ce_q;

        if (cnt_q == CNT_W'(DIV - 1)) begin
            cnt_d = '0;
        end
        if (cnt_q == CNT_W'(DIV - 2)) begin
            ce_d = 1'b1;
        end
        sample_ce_d = ce_d & (STEREO ? phase_q : 1'b1);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q       <= '0;
            ce_q        <= 1'b0;
            sample_ce_q <= 1'b0;
            phase_q     <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            ce_q        <= ce_d;
            sample_ce_q <= sample_ce_d;
            phase_q     <= phase_d;
        end
    end

    assign ce        = ce_q;
    assign sample_ce = sample_ce_q;

endmodule

// File: rtl/iir_coeff_ctrl.sv
// Coefficient shadow/active banks and commit sequencer for the stereo IIR
// filter; swaps banks only on a sample boundary and optionally flushes state.
module iir_coeff_ctrl
    import iir_ctrl_pkg::*;
#(
    parameter int unsigned DIV    = 512,
    parameter bit          STEREO = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    iir_coeff_ctrl_if.slave  cfg,
    output logic             ce,
    output logic             sample_ce,
    output logic             filt_reset,
    output logic [CX_W-1:0]  cx,
    output logic [XS_W-1:0]  cx0,
    output logic [XS_W-1:0]  cx1,
    output logic [XS_W-1:0]  cx2,
    output logic [CY_W-1:0]  cy0,
    output logic [CY_W-1:0]  cy1,
    output logic [CY_W-1:0]  cy2
);

    state_t                           state_q, state_d;
    logic [NUM_BYTES-1:0][BYTE_W-1:0] shadow_q, shadow_d;
    coeff_t                           active_q, active_d;
    logic                             flush_q, flush_d;
    logic                             busy_q, busy_d;
    logic                             wr_err_q, wr_err_d;
    logic                             filt_reset_q, filt_reset_d;

    iir_ce_gen #(
        .DIV    (DIV),
        .STEREO (STEREO)
    ) u_ce_gen (
        .clk       (clk),
        .reset     (reset),
        .ce        (ce),
        .sample_ce (sample_ce)
    );

    // Next-state, bank update and status decode.
    always_comb begin
        state_d      = state_q;
        shadow_d     = shadow_q;
        active_d     = active_q;
        flush_d      = flush_q;
        busy_d       = busy_q;
        wr_err_d     = 1'b0;
        filt_reset_d = 1'b0;

        case (state_q)
            IDLE: begin
                // A write on the commit cycle lands first, so it joins the swap.
                if (cfg.wr_en) begin
                    if (addr_valid(cfg.wr_addr)) begin
                        for (int unsigned i = 0; i < NUM_BYTES; i++) begin
                            if (cfg.wr_addr == ADDR_W'(i)) begin
                                shadow_d[i] = cfg.wr_data;
                            end
                        end
                    end else begin
                        wr_err_d = 1'b1;
                    end
                end
                if (cfg.commit) begin
                    state_d = PEND;
                    flush_d = cfg.wr_data[0];
                    busy_d  = 1'b1;
                end
            end

            PEND: begin
                if (cfg.wr_en || cfg.commit) begin
                    wr_err_d = 1'b1;
                end
                if (sample_ce) begin
                    active_d = coeff_t'(shadow_q);
                    if (flush_q) begin
                        state_d      = FLUSH;
                        filt_reset_d = 1'b1;
                    end else begin
                        state_d = IDLE;
                        busy_d  = 1'b0;
                    end
                end
            end

            FLUSH: begin
                if (cfg.wr_en || cfg.commit) begin
                    wr_err_d = 1'b1;
                end
                state_d = IDLE;
                busy_d  = 1'b0;
            end

            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            shadow_q     <= '0;
            active_q     <= '0;
            flush_q      <= 1'b0;
            busy_q       <= 1'b0;
            wr_err_q     <= 1'b0;
            filt_reset_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            shadow_q     <= shadow_d;
            active_q     <= active_d;
            flush_q      <= flush_d;
            busy_q       <= busy_d;
            wr_err_q     <= wr_err_d;
            filt_reset_q <= filt_reset_d;
        end
    end

    assign cfg.busy   = busy_q;
    assign cfg.wr_err = wr_err_q;
    assign filt_reset = filt_reset_q;

    assign cx  = active_q.cx;
    assign cx0 = active_q.cx0;
    assign cx1 = active_q.cx1;
    assign cx2 = active_q.cx2;
    assign cy0 = active_q.cy0;
    assign cy1 = active_q.cy1;
    assign cy2 = active_q.cy2;

endmodule

// File: doc/iir_coeff_ctrl.md
Name: iir_coeff_ctrl

Overview:
Run-time configuration and sequencing controller for the 3-tap stereo IIR filter when that filter runs with use_params=0.
- Generates the filter's ce (2x sample rate) and sample_ce strobes from clk.
- Accepts byte-wide coefficient writes from the HPS config bus into a shadow bank.
- On commit, swaps the shadow bank into the active bank only on a sample boundary, optionally flushing the filter state.

Parameters:
- DIV, 512: clk cycles per ce pulse (DIV >= 4).
- STEREO, 1: 1 = sample_ce on every 2nd ce; 0 = sample_ce on every ce.

Ports:
- clk  in  1  clock
- reset  in  1  reset, asynchronous, active-high
- wr_en  in  1  config byte write strobe
- wr_addr  in  5  byte address (map below)
- wr_data  in  8  write data
- commit  in  1  request shadow->active swap; wr_data[0] sampled as flush flag
- busy  out  1  commit pending or flush in progress
- wr_err  out  1  one-cycle pulse: write/commit rejected
- ce  out  1  filter compute strobe
- sample_ce  out  1  output sample strobe
- filt_reset  out  1  one-cycle filter state flush
- cx  out  40  active base gain
- cx0, cx1, cx2  out  8 each  active X scale factors
- cy0, cy1, cy2  out  24 each  active Y coefficients

Behaviour:
- Reset values: all outputs 0; shadow and active banks 0; div counter 0; phase 0; state IDLE. The filter outputs silence until the first commit.
- Address map, little-endian bytes:
  - cx: 0..4
  - cx0: 5; cx1: 6; cx2: 7
  - cy0: 8..10; cy1: 11..13; cy2: 14..16
  - Addresses 17..31: write ignored, wr_err pulsed.
- Strobe generator:
  - cnt counts 0..DIV-1 and wraps.
  - ce is registered, high for exactly 1 cycle when cnt==DIV-1.
  - phase toggles on each ce.
  - sample_ce = ce & phase when STEREO=1, so the first sample_ce occurs on the 2nd ce after reset. sample_ce = ce when STEREO=0.
  - The strobes are free-running and unaffected by FSM state.
- FSM states: IDLE, PEND, FLUSH.
  - IDLE:
    - wr_en with a valid address writes the shadow byte on that edge.
    - commit → PEND; latch flush=wr_data[0]; busy=1 from the next cycle.
    - If wr_en and commit are high together, the write lands first and is included in the swap.
  - PEND:
    - On the edge where sample_ce=1, copy the shadow bank to the active bank; outputs change the cycle after sample_ce.
    - Then go to FLUSH if flush=1, else IDLE.
    - wr_en or commit in PEND: ignored, wr_err pulsed 1 cycle; the shadow bank is not modified.
  - FLUSH:
    - filt_reset=1 for exactly 1 cycle, registered and coincident with the first cycle of new coefficients. This keeps old state from ringing through the new coefficients.
    - Then IDLE; busy drops the same cycle filt_reset drops.
  - Commit arriving on the same cycle as sample_ce in IDLE: not swapped on that strobe; waits for the next sample_ce.
- Active coefficients never change except on a sample_ce edge. They are never torn across a stereo channel pair.
- Async reset mid-PEND/FLUSH: everything returns to reset values; the pending commit is lost; filt_reset is not asserted by reset itself.
- No arithmetic beyond the counter. cnt width is clog2(DIV).

Decomposition:
- Package iir_ctrl_pkg:
  - Address constants: ADDR_CX=0, ADDR_CX0=5, ADDR_CX1=6, ADDR_CX2=7, ADDR_CY0=8, ADDR_CY1=11, ADDR_CY2=14, ADDR_LAST=16.
  - State enum {IDLE, PEND, FLUSH}.
  - Width constants: CX_W=40, CY_W=24.
- Sub-module iir_ce_gen (DIV, STEREO) produces ce and sample_ce. The top holds the register bank and FSM.

Test Plan:
- Strobes, DIV=8, STEREO=1: after reset release, ce high at cycles 7, 15, 23, 31; sample_ce high at 15 and 31 only; each pulse width 1.
- Basic load: write bytes 0..16 = 0x01..0x11, commit with wr_data=0. Required: busy=1 until the first sample_ce; cx=0x0504030201, cx0=06, cy2=0x11100F the cycle after sample_ce; filt_reset stays 0.
- Flush: commit with wr_data[0]=1. Required: one filt_reset pulse coincident with the new coefficients; busy low the next cycle.
- Busy rejection: in PEND, write addr 5 = 0xAA and issue a second commit. Required: two wr_err pulses; after the swap, cx0 keeps its pre-PEND shadow value.
- Bad address: write addr 20. Required: wr_err pulse; no shadow or active bank change; state stays IDLE.
- Reset mid-PEND: assert reset 3 cycles after commit. Required: all coefficients 0, busy 0, no swap or filt_reset at the following sample_ce.
